// File: rtl/tree_cls_pkg.sv
// Shared types and width helpers for the programmable decision-tree walker and
// its forest wrapper.
package tree_cls_pkg;

    localparam int DEF_N_FEAT    = 51;
    localparam int DEF_N_NODES   = 64;
    localparam int DEF_MAX_DEPTH = 16;
    localparam int DEF_CLASS_W   = 2;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int node_w(input int n_feat, input int n_nodes, input int class_w);
        return 1 + idx_w(n_feat) + 2 * idx_w(n_nodes) + class_w;
    endfunction

    localparam int DEF_FIDX_W = idx_w(DEF_N_FEAT);
    localparam int DEF_NIDX_W = idx_w(DEF_N_NODES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    // Field order matches the cfg_wdata packing: {is_leaf, feat_idx, child_t, child_f, class}.
    typedef struct packed {
        logic                   is_leaf;
        logic [DEF_FIDX_W-1:0]  feat_idx;
        logic [DEF_NIDX_W-1:0]  child_t;
        logic [DEF_NIDX_W-1:0]  child_f;
        logic [DEF_CLASS_W-1:0] leaf_class;
    } node_t;

endpackage

// File: rtl/tree_node_mem.sv
// Node table: flop array with one write port and an asynchronous read port.
// Cleared to zero on reset so an unprogrammed tree can never yield a class.
module tree_node_mem #(
    parameter int N_NODES = 64,
    parameter int NIDX_W  = 6,
    parameter int NODE_W  = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [NIDX_W-1:0] waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [NIDX_W-1:0] raddr,
    output logic [NODE_W-1:0] rdata
);

    logic [NODE_W-1:0] mem_reg [0:N_NODES-1];

    generate
        for (genvar gi = 0; gi < N_NODES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (we && (waddr == NIDX_W'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/tree_walk_classifier.sv
// Sequential binary decision-tree classifier: latches one feature vector, walks
// the node table one node per clock and returns the leaf class over valid/ready.
module tree_walk_classifier
    import tree_cls_pkg::*;
#(
    parameter  int N_FEAT    = DEF_N_FEAT,
    parameter  int N_NODES   = DEF_N_NODES,
    parameter  int MAX_DEPTH = DEF_MAX_DEPTH,
    parameter  int CLASS_W   = DEF_CLASS_W,
    localparam int FIDX_W    = idx_w(N_FEAT),
    localparam int NIDX_W    = idx_w(N_NODES),
    localparam int NODE_W    = node_w(N_FEAT, N_NODES, CLASS_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [NIDX_W-1:0]  cfg_addr,
    input  logic [NODE_W-1:0]  cfg_wdata,
    output logic               cfg_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT-1:0]  in_feat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic [4:0]         out_depth
);

    // Feature vector padded to the full index range so indices >= N_FEAT read 0.
    localparam int FEXT_W = 1 << FIDX_W;

    state_t              state_reg, state_next;
    logic [N_FEAT-1:0]   feat_reg, feat_next;
    logic [NIDX_W-1:0]   cur_reg, cur_next;
    logic [4:0]          depth_reg, depth_next;
    logic [CLASS_W-1:0]  class_reg, class_next;
    logic                err_reg, err_next;

    logic [NODE_W-1:0]   node_word;
    logic                node_is_leaf;
    logic [FIDX_W-1:0]   node_feat_idx;
    logic [NIDX_W-1:0]   node_child_t;
    logic [NIDX_W-1:0]   node_child_f;
    logic [CLASS_W-1:0]  node_class;
    logic [FEXT_W-1:0]   feat_ext;
    logic [NIDX_W-1:0]   sel_child;
    logic                is_idle;

    assign is_idle   = (state_reg == IDLE);
    assign cfg_ready = is_idle;
    assign in_ready  = is_idle;
    assign out_valid = (state_reg == DONE);
    assign out_class = class_reg;
    assign out_err   = err_reg;
    assign out_depth = depth_reg;

    tree_node_mem #(
        .N_NODES (N_NODES),
        .NIDX_W  (NIDX_W),
        .NODE_W  (NODE_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we && cfg_ready),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (cur_reg),
        .rdata (node_word)
    );

    assign node_class    = node_word[CLASS_W-1:0];
    assign node_child_f  = node_word[CLASS_W +: NIDX_W];
    assign node_child_t  = node_word[CLASS_W+NIDX_W +: NIDX_W];
    assign node_feat_idx = node_word[CLASS_W+2*NIDX_W +: FIDX_W];
    assign node_is_leaf  = node_word[NODE_W-1];

    assign feat_ext  = FEXT_W'(feat_reg);
    assign sel_child = feat_ext[node_feat_idx] ? node_child_t : node_child_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            feat_reg  <= '0;
            cur_reg   <= '0;
            depth_reg <= '0;
            class_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            feat_reg  <= feat_next;
            cur_reg   <= cur_next;
            depth_reg <= depth_next;
            class_reg <= class_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        feat_next  = feat_reg;
        cur_next   = cur_reg;
        depth_next = depth_reg;
        class_next = class_reg;
        err_next   = err_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    feat_next  = in_feat;
                    cur_next   = '0;
                    depth_next = '0;
                    state_next = WALK;
                end
            end
            WALK: begin
                if (node_is_leaf) begin
                    class_next = node_class;
                    err_next   = 1'b0;
                    state_next = DONE;
                end else if (depth_reg == 5'(MAX_DEPTH)) begin
                    class_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else if (int'(sel_child) >= N_NODES) begin
                    class_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cur_next   = sel_child;
                    depth_next = depth_reg + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tree_walk_classifier.sv
// Randomised bench for tree_walk_classifier against a table-walk reference model.
module tb_tree_walk_classifier;
    import tree_cls_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [20:0] cfg_wdata = '0;
    logic        cfg_ready;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [50:0] in_feat = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_class;
    logic        out_err;
    logic [4:0]  out_depth;

    int    checks = 0;
    int    errors = 0;
    node_t tbl [64];

    tree_walk_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .out_depth (out_depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic node_t mk(input bit leaf, input int fi, input int ct, input int cf, input int cl);
        node_t n;
        n.is_leaf    = leaf;
        n.feat_idx   = 6'(fi);
        n.child_t    = 6'(ct);
        n.child_f    = 6'(cf);
        n.leaf_class = 2'(cl);
        return n;
    endfunction

    // Reference: follow the tree from the root; depth counts internal nodes passed.
    task automatic model(input logic [50:0] f, output int cls, output int err, output int depth);
        int cur = 0;
        depth = 0;
        forever begin
            node_t n = tbl[cur];
            bit    b;
            if (n.is_leaf) begin
                cls = int'(n.leaf_class); err = 0; return;
            end
            if (depth == 16) begin
                cls = 0; err = 1; return;
            end
            b = (int'(n.feat_idx) < 51) ? f[n.feat_idx] : 1'b0;
            cur = b ? int'(n.child_t) : int'(n.child_f);
            if (cur >= 64) begin
                cls = 0; err = 1; return;
            end
            depth++;
        end
    endtask

    task automatic prog(input int a, input node_t n);
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_wdata = n;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tbl[a] = n;
    endtask

    // Called #1 after the accept edge; returns #1 after the edge that raised out_valid.
    task automatic wait_result(input logic [50:0] f, input bit busy_wr,
                               output int ec, output int ee, output int ed);
        int lat = 0;
        model(f, ec, ee, ed);
        if (busy_wr) begin
            check("cfg_ready_busy", cfg_ready, 0);
            cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = mk(1, 0, 0, 0, 3);
        end
        do begin
            @(posedge clk); #1;
            cfg_we = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
        check("latency", lat, ed + 1);
        check("out_class", out_class, ec);
        check("out_err", out_err, ee);
        check("out_depth", out_depth, ed);
        $display("walk feat=%013h class=%0d err=%0d depth=%0d lat=%0d", f, out_class, out_err, out_depth, lat);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic run_walk(input logic [50:0] f, input bit busy_wr, input int hold);
        int ec, ee, ed, c2, e2, d2;
        logic [50:0] f2;
        check("in_ready_idle", in_ready, 1);
        in_feat = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(f, busy_wr, ec, ee, ed);
        if (hold == 0) begin
            release_out();
        end else begin
            f2 = {$urandom, $urandom};
            in_feat = f2; in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 1);
                check("hold_class", out_class, ec);
                check("hold_err", out_err, ee);
                check("hold_depth", out_depth, ed);
                check("hold_in_ready", in_ready, 0);
            end
            release_out();
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("accept_after_release", in_ready, 0);
            wait_result(f2, 1'b0, c2, e2, d2);
            release_out();
        end
    endtask

    initial begin
        logic [50:0] f;
        for (int i = 0; i < 64; i++) tbl[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_depth", out_depth, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-level tree on feature 13
        prog(0, mk(0, 13, 1, 2, 0));
        prog(1, mk(1, 0, 0, 0, 0));
        prog(2, mk(1, 0, 0, 0, 1));
        f = {$urandom, $urandom}; f[13] = 1'b1;
        run_walk(f, 0, 0);
        f = {$urandom, $urandom}; f[13] = 1'b0;
        run_walk(f, 0, 0);

        // Write while busy must not land; rerun the feature-13 case
        f = {$urandom, $urandom}; f[13] = 1'b1;
        run_walk(f, 1, 0);
        run_walk(f, 0, 0);
        check("busy_write_ignored", out_class, 0);

        // Backpressure: hold the result for 10 cycles with a pending request
        run_walk(f, 0, 10);

        // Root leaf
        prog(0, mk(1, 0, 0, 0, 3));
        run_walk({$urandom, $urandom}, 0, 0);

        // Self loop -> depth overflow
        prog(0, mk(0, 0, 0, 0, 0));
        run_walk({$urandom, $urandom}, 0, 0);

        // Random tables, including feature indices beyond the vector
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 64; i++)
                prog(i, mk($urandom_range(0, 2) == 0, $urandom_range(0, 63),
                           $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3)));
            for (int k = 0; k < 10; k++) run_walk({$urandom, $urandom}, 0, 0);
        end

        // Reset in the middle of a walk at depth 2
        prog(0, mk(0, 0, 1, 1, 0));
        prog(1, mk(0, 0, 2, 2, 0));
        prog(2, mk(0, 0, 3, 3, 0));
        prog(3, mk(1, 0, 0, 0, 2));
        in_feat = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_walk_depth", out_depth, 2);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_depth", out_depth, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) tbl[i] = '0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);
        run_walk({$urandom, $urandom}, 0, 0);
        check("cleared_table_err", out_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
